// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helper for the AES-128 key schedule blocks.
package aes_pkg;

  // Four 32-bit words; word 0 is the most significant (FIPS-197 w[i] ordering).
  typedef logic [0:3][31:0] round_key_t;

  localparam int unsigned AES128_NR = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStep,
    StWait,
    StDone
  } ks_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the key schedule. load_i restarts the sequence at
// RCON_INIT, adv_i steps it by xtime(). rcon_nxt_o is the value the register
// takes at the coming edge, so a registered consumer can capture it in step.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] rcon_nxt_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  // Next Rcon value: load wins over advance.
  always_comb begin
    rcon_d = rcon_q;
    if (load_i) begin
      rcon_d = RCON_INIT;
    end else if (adv_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  // Rcon register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcon_q <= '0;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_nxt_o = rcon_d;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer and round-key store. Steps an external key-gen
// round stage NR times and captures each round key into an (NR+1)-entry store
// read through a registered port.
// Optional feature: define AES_KEY_SCHED_ZEROIZE_EN to add zeroize_i, which wipes
// the store, the read register and the forwarded key and forces the FSM idle.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR     = AES128_NR,
  parameter int unsigned KG_LAT = 2,
  parameter int unsigned RCON_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  input  logic              zeroize_i,
`endif
  input  logic [0:3][31:0]  key_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              kg_en_o,
  output logic              kg_next_rnd_o,
  output logic [0:3][31:0]  kg_key_o,
  output logic [RCON_W-1:0] kg_rcon_o,
  input  logic [0:3][31:0]  kg_key_i,
  input  logic [3:0]        rk_idx_i,
  output logic [0:3][31:0]  rk_o,
  output logic [NR:0]       rk_avail_o
);

  localparam int unsigned CntW = (KG_LAT > 1) ? $clog2(KG_LAT) : 1;

  ks_state_e         state_q;
  logic              busy_q;
  logic              done_q;
  logic              kg_en_q;
  logic              kg_next_rnd_q;
  round_key_t        kg_key_q;
  logic [RCON_W-1:0] kg_rcon_q;
  logic [NR:0]       rk_avail_q;
  logic [3:0]        r_q;
  logic [CntW-1:0]   cnt_q;
  round_key_t        store_q [NR+1];
  round_key_t        rk_q;

  logic              wipe;
  logic              rcon_load;
  logic              rcon_adv;
  logic              last_wait;
  logic [7:0]        rcon_nxt;

  // Zeroize behaves like reset for every piece of state in this block.
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  assign wipe = rst | zeroize_i;
`else
  assign wipe = rst;
`endif

  assign last_wait = (state_q == StWait) && (cnt_q == '0);
  assign rcon_load = (state_q == StLoad);
  assign rcon_adv  = last_wait;

  aes_rcon_gen u_rcon_gen (
    .clk        (clk),
    .rst        (wipe),
    .load_i     (rcon_load),
    .adv_i      (rcon_adv),
    .rcon_nxt_o (rcon_nxt)
  );

  // Sequencer FSM with registered outputs and the round-key store. Step outputs
  // are set on the edge entering StStep so kg_en_o is high for exactly that cycle.
  always_ff @(posedge clk) begin
    if (wipe) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      kg_en_q       <= 1'b0;
      kg_next_rnd_q <= 1'b0;
      kg_key_q      <= '0;
      kg_rcon_q     <= '0;
      rk_avail_q    <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      for (int i = 0; i <= int'(NR); i++) begin
        store_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          store_q[0]    <= key_i;
          // A new expansion invalidates every derived key from the last run.
          rk_avail_q    <= '0;
          rk_avail_q[0] <= 1'b1;
          kg_key_q      <= key_i;
          r_q           <= 4'd1;
          kg_en_q       <= 1'b1;
          kg_next_rnd_q <= 1'b0;
          kg_rcon_q     <= {{(RCON_W-8){1'b0}}, rcon_nxt};
          state_q       <= StStep;
        end
        StStep: begin
          kg_en_q <= 1'b0;
          cnt_q   <= CntW'(KG_LAT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            store_q[r_q]    <= kg_key_i;
            rk_avail_q[r_q] <= 1'b1;
            if (r_q == 4'(NR)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              r_q           <= r_q + 4'd1;
              // Rounds after the first chain from the key-gen stage's own output.
              kg_en_q       <= 1'b1;
              kg_next_rnd_q <= 1'b1;
              kg_rcon_q     <= {{(RCON_W-8){1'b0}}, rcon_nxt};
              state_q       <= StStep;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (wipe) begin
      rk_q <= '0;
    end else if (int'(rk_idx_i) <= int'(NR)) begin
      rk_q <= store_q[rk_idx_i];
    end else begin
      rk_q <= '0;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign kg_en_o       = kg_en_q;
  assign kg_next_rnd_o = kg_next_rnd_q;
  assign kg_key_o      = kg_key_q;
  assign kg_rcon_o     = kg_rcon_q;
  assign rk_o          = rk_q;
  assign rk_avail_o    = rk_avail_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl. A behavioural FIPS-197 key-gen
// stage feeds kg_key_i; a timeline model of the schedule is compared against
// the DUT outputs every cycle. Define AES_KEY_SCHED_ZEROIZE_EN to cover zeroize.
module tb_aes_key_sched_ctrl;

  localparam int NR = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  logic             zeroize_i = 1'b0;
`endif
  logic [0:3][31:0] key_i = '0;
  logic             busy_o;
  logic             done_o;
  logic             kg_en_o;
  logic             kg_next_rnd_o;
  logic [0:3][31:0] kg_key_o;
  logic [9:0]       kg_rcon_o;
  logic [0:3][31:0] kg_key_i;
  logic [3:0]       rk_idx_i = '0;
  logic [0:3][31:0] rk_o;
  logic [NR:0]      rk_avail_o;

  aes_key_sched_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    .zeroize_i     (zeroize_i),
`endif
    .key_i         (key_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .kg_en_o       (kg_en_o),
    .kg_next_rnd_o (kg_next_rnd_o),
    .kg_key_o      (kg_key_o),
    .kg_rcon_o     (kg_rcon_o),
    .kg_key_i      (kg_key_i),
    .rk_idx_i      (rk_idx_i),
    .rk_o          (rk_o),
    .rk_avail_o    (rk_avail_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- GF(2^8) arithmetic and S-box built from first principles
  logic [7:0] sbox [256];
  logic [7:0] rcon_tab [NR];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] rc;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    for (int i = 0; i < NR; i++) begin
      rcon_tab[i] = rc;
      rc = gmul(rc, 8'h02);
    end
  endtask

  function automatic logic [127:0] kg_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rw, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    rw = {w3[23:0], w3[31:24]};
    t  = {sbox[rw[31:24]], sbox[rw[23:16]], sbox[rw[15:8]], sbox[rw[7:0]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- behavioural key-gen stage: result valid 2 cycles after kg_en_o
  logic [127:0] kg1, kg2;
  always @(posedge clk) begin
    if (kg_en_o) kg1 <= kg_step(kg_next_rnd_o ? kg1 : kg_key_o, kg_rcon_o[7:0]);
    kg2 <= kg1;
  end
  assign kg_key_i = kg2;

  // ---------------- timeline model: m_k counts edges since the start sample edge
  bit           m_active = 1'b0;
  int           m_k = 0;
  logic [127:0] m_store [NR+1];
  logic [127:0] m_exp   [NR+1];
  logic [NR:0]  m_avail = '0;
  logic [127:0] m_rk = '0;
  logic [127:0] m_kg_key = '0;

  always @(posedge clk) begin
    bit wipe;
    wipe = rst;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    wipe = wipe | zeroize_i;
`endif
    if (wipe) begin
      m_active = 1'b0;
      m_k      = 0;
      m_avail  = '0;
      m_rk     = '0;
      m_kg_key = '0;
      for (int i = 0; i <= NR; i++) m_store[i] = '0;
    end else begin
      m_rk = (int'(rk_idx_i) <= NR) ? m_store[rk_idx_i] : '0;
      if (!m_active) begin
        if (start_i) begin
          m_active = 1'b1;
          m_k      = 0;
        end
      end else begin
        m_k++;
        if (m_k == 1) begin
          m_exp[0] = key_i;
          for (int i = 1; i <= NR; i++) m_exp[i] = kg_step(m_exp[i-1], rcon_tab[i-1]);
          m_store[0] = key_i;
          m_avail    = 1;
          m_kg_key   = key_i;
        end else if ((m_k - 1) % 3 == 0 && (m_k - 1) / 3 <= NR) begin
          m_store[(m_k-1)/3] = m_exp[(m_k-1)/3];
          m_avail[(m_k-1)/3] = 1'b1;
        end
        if (m_k == 3 * NR + 2) m_active = 1'b0;
      end
    end
  end

  // ---------------- compare process, plus done counter and step-pulse log
  int         n_done = 0;
  bit         log_on = 1'b0;
  int         n_log = 0;
  logic [9:0] log_rcon [16];
  logic       log_nr [16];

  always @(negedge clk) begin
    bit e_step;
    e_step = m_active && m_k >= 1 && m_k <= 3 * NR - 2 && (m_k - 1) % 3 == 0;
    chk("busy", busy_o, m_active && m_k <= 3 * NR);
    chk("done", done_o, m_active && m_k == 3 * NR + 1);
    chk("kg_en", kg_en_o, e_step);
    chk("rk_avail", rk_avail_o, m_avail);
    chk("rk", rk_o, m_rk);
    chk("kg_key", kg_key_o, m_kg_key);
    if (e_step) begin
      chk("kg_next_rnd", kg_next_rnd_o, m_k > 1);
      chk("kg_rcon", kg_rcon_o, {2'b00, rcon_tab[(m_k-1)/3]});
    end
    if (done_o) n_done++;
    if (log_on && kg_en_o && n_log < 16) begin
      log_rcon[n_log] = kg_rcon_o;
      log_nr[n_log]   = kg_next_rnd_o;
      n_log++;
    end
  end

  // ---------------- stimulus helpers (inputs change 2 time units after posedge)
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input logic [127:0] key);
    key_i   = key;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Edges from the last tick until done_o is seen; bounded.
  task automatic wait_done(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      n++;
      if (done_o) got = 1'b1;
    end
    if (!got) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    rk_idx_i = 4'(idx);
    tick();
    v = rk_o;
  endtask

  localparam logic [127:0] KEY   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] RK1   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] RK10  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  initial begin
    int n;
    int d0;
    logic [127:0] v;
    logic [9:0] rcon_lit [10];
    rcon_lit = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                 10'h020, 10'h040, 10'h080, 10'h01B, 10'h036};

    build_tables();
    chk("sbox_00", sbox[0], 8'h63);
    chk("sbox_53", sbox[8'h53], 8'hed);

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_avail", rk_avail_o, '0);
    chk("rst_rk", rk_o, '0);
    chk("rst_kg_en", kg_en_o, 1'b0);

    // Test 1: FIPS-197 example key; done_o visible in the 32nd cycle after the
    // start sample edge, i.e. after edge 31.
    log_on = 1'b1;
    start_run(KEY);
    wait_done(n);
    log_on = 1'b0;
    chk("t1_latency", n, 31);
    chk("model_rk10", m_exp[10], RK10);
    chk("model_rk1", m_exp[1], RK1);
    tick();
    chk("t1_done_pulse", done_o, 1'b0);
    read_rk(10, v);
    chk("t1_rk10", v, RK10);
    read_rk(1, v);
    chk("t1_rk1", v, RK1);
    read_rk(0, v);
    chk("t1_rk0", v, KEY);

    // Test 2: Rcon and feedback select on every step pulse
    chk("t2_pulses", n_log, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_rcon%0d", i), log_rcon[i], rcon_lit[i]);
      chk($sformatf("t2_next%0d", i), log_nr[i], i != 0);
    end

    // Test 5a: out-of-range index reads zero
    read_rk(11, v);
    chk("t5_idx11", v, '0);
    read_rk(15, v);
    chk("t5_idx15", v, '0);

    // Test 3: start pulsed mid-run is ignored
    d0 = n_done;
    start_run(KEY);
    repeat (4) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(n);
    chk("t3_latency", n, 26);
    repeat (5) tick();
    chk("t3_one_done", n_done - d0, 1);
    read_rk(10, v);
    chk("t3_rk10", v, RK10);

    // Test 5b + Test 4: index 3 before capture, then reset at cycle 12
    rk_idx_i = 4'd3;
    start_run(KEY);
    repeat (5) tick();
    chk("t5_avail3", rk_avail_o[3], 1'b0);
    chk("t5_avail1", rk_avail_o[1], 1'b1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", busy_o, 1'b0);
    chk("t4_avail", rk_avail_o, '0);
    d0 = n_done;
    repeat (40) tick();
    chk("t4_no_done", n_done - d0, 0);
    start_run(KEY);
    wait_done(n);
    chk("t4_latency", n, 31);
    read_rk(10, v);
    chk("t4_rk10", v, RK10);
    read_rk(1, v);
    chk("t4_rk1", v, RK1);

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    // Test 6: zeroize mid-run, then a clean restart
    d0 = n_done;
    start_run(KEY);
    repeat (10) tick();
    zeroize_i = 1'b1;
    tick();
    zeroize_i = 1'b0;
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_avail", rk_avail_o, '0);
    chk("t6_rk", rk_o, '0);
    chk("t6_kg_key", kg_key_o, '0);
    read_rk(0, v);
    chk("t6_rk0", v, '0);
    repeat (40) tick();
    chk("t6_no_done", n_done - d0, 0);
    start_run(KEY);
    wait_done(n);
    chk("t6_latency", n, 31);
    read_rk(10, v);
    chk("t6_rk10", v, RK10);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
